md_unit: RTL and testbench

- Parametrised multiply/divide unit that sits beside the execute-stage ALU in the pipelined CPU.
- Accepts one operation per start pulse, latches the operands, and counts a fixed multi-cycle latency.
- Writes HI/LO only at completion, and exposes busy so the hazard unit can stall md-dependent instructions.
- Supports signed/unsigned mult and div plus direct HI/LO writes (mthi/mtlo).

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_compute.sv | 68 ++++++
 rtl/md_unit.sv | 85 ++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state codes and op-class helpers.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Produces the full {hi,lo} result
// for the requested op; the caller registers it when the op is accepted.
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_by_zero
);

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, q_u, r_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the
  // signed product, so both multiplies stay in unsigned arithmetic.
  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign div_by_zero = is_div_op(op) && (B == '0);
  assign b_safe      = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;

  assign q_u = A / b_safe;
  assign r_u = A % b_safe;

  // Sign-magnitude division: most-negative / -1 wraps back to A with a zero
  // remainder without special casing.
  assign a_neg = A[WIDTH-1];
  assign b_neg = b_safe[WIDTH-1];
  assign a_mag = a_neg ? (-A) : A;
  assign b_mag = b_neg ? (-b_safe) : b_safe;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
  assign r_s   = a_neg ? (-r_mag) : r_mag;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV: begin
        hi_res = r_s;
        lo_res = q_s;
      end
      MD_DIVU: begin
        hi_res = r_u;
        lo_res = q_u;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Handshake: a request
// is accepted when start=1 in IDLE; busy/stall_req hold the requester until done.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_dz;

  logic [WIDTH-1:0] hi_res, lo_res;
  logic             div_by_zero;

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op          (op),
    .A           (A),
    .B           (B),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  assign busy      = (state == ST_RUN);
  assign stall_req = busy || (start && is_md_op(op));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      HI     <= '0;
      LO     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_dz <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        if (is_md_op(op)) begin
          state  <= ST_RUN;
          cnt    <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
          res_hi <= hi_res;
          res_lo <= lo_res;
          res_dz <= div_by_zero;
        end else if (op == MD_MTHI) begin
          HI <= A;
        end else if (op == MD_MTLO) begin
          LO <= A;
        end
      end
    end else begin
      // Any start seen while running is dropped; only the countdown matters.
      if (cnt == CNT_LAST) begin
        state <= ST_IDLE;
        cnt   <= '0;
        if (!res_dz) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO/latency queued at issue time and
// checked by an independent monitor when busy drops.
module tb_md_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, stall_req;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W+7:0] exp_q[$];
  logic [2*W+7:0] e;

  // clock / reset
  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (hi),
    .LO        (lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic rst_at_edge = 1'b0;
  logic prev_busy   = 1'b0;
  int   run_len     = 0;

  always @(posedge clk) rst_at_edge = reset;

  always @(negedge clk) begin
    if (rst_at_edge === 1'b1) begin
      run_len = 0;
    end else if (busy === 1'b1) begin
      run_len++;
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: got HI=0x%08h LO=0x%08h required no completion", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("hi", hi, e[2*W-1:W]);
        check("lo", lo, e[W-1:0]);
        check("busy_cycles", W'(run_len), W'(e[2*W+7:2*W]));
      end
      run_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  // driver tasks
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1;
    check("stall_req_on_start", W'(stall_req), W'((o >= 3'd1) && (o <= 3'd4)));
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle_timeout: got busy=%0b required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input int cyc);
    exp_q.push_back({8'(cyc), ehi, elo});
    issue(o, x, y);
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", W'(busy), 32'h0);
    check("reset_stall", W'(stall_req), 32'h0);

    run_op(3'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op(3'd2, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op(3'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);

    issue(3'd5, 32'h11, 32'h0);
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", W'(busy), 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_busy", W'(busy), 32'h0);

    run_op(3'd4, 32'h7, 32'h0, 32'h11, 32'h22, 10);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    run_op(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5);

    // op 7 is a no-op
    issue(3'd7, 32'h55, 32'h66);
    check("op7_hi", hi, 32'h40000000);
    check("op7_lo", lo, 32'h0);
    check("op7_busy", W'(busy), 32'h0);

    // DIV issued in busy cycle 2 of a MULT must be ignored
    exp_q.push_back({8'd5, 32'h0, 32'd42});
    issue(3'd1, 32'd6, 32'd7);
    check("stall_while_busy", W'(stall_req), 32'h1);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd3;
    a     = 32'd100;
    b     = 32'd3;
    #1;
    check("stall_overlap", W'(stall_req), 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("overlap_hi", hi, 32'h0);
    check("overlap_lo", lo, 32'd42);
    check("overlap_busy", W'(busy), 32'h0);

    // reset in busy cycle 3 aborts the MULT
    issue(3'd1, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", W'(busy), 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (10) @(negedge clk);
    check("abort_late_hi", hi, 32'h0);
    check("abort_late_lo", lo, 32'h0);
    check("abort_late_busy", W'(busy), 32'h0);

    check("queue_drained", W'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
